// File: rtl/uart_pkg.sv
// Shared register map, STATUS/CTRL bit positions and engine state types
// for the FIFO-buffered UART peripheral.
package uart_pkg;

  localparam logic [2:0] UART_REG_DATA   = 3'd0;
  localparam logic [2:0] UART_REG_STATUS = 3'd1;
  localparam logic [2:0] UART_REG_CTRL   = 3'd2;
  localparam logic [2:0] UART_REG_DIVLO  = 3'd3;
  localparam logic [2:0] UART_REG_DIVHI  = 3'd4;

  localparam int ST_RX_AVAIL  = 0;
  localparam int ST_OVERRUN   = 1;
  localparam int ST_TX_BUSY   = 2;
  localparam int ST_TX_FULL   = 3;
  localparam int ST_FRAME_ERR = 4;
  localparam int ST_TX_IDLE   = 5;
  localparam int ST_TX_DROP   = 6;

  localparam int CTRL_RX_INT_EN = 0;
  localparam int CTRL_TX_INT_EN = 1;
  localparam int CTRL_LOOPBACK  = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a combinational head; a pop frees room for a push
// in the same cycle, and a pop on empty is ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [AW:0]      count_q;
  logic             doPush, doPop;

  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata;
  end

  assign rdata = mem_q[rdPtr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_buffered.sv
// FIFO-buffered UART for the 8-bit peripheral bus: TX/RX shift engines,
// programmable divisor, loopback, sticky error flags and maskable interrupts.
module uart_buffered
  import uart_pkg::*;
#(
  parameter int SYS_CLK    = 50_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int RX_THRESH  = 1,
  parameter int DIV_W      = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_dat,
  output logic [7:0] o_dat,
  input  logic [2:0] i_addr,
  input  logic       i_we,
  input  logic       i_cyc,
  input  logic       rx,
  output logic       tx,
  output logic [1:0] o_int
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(SYS_CLK / BAUDRATE - 1);

  logic [2:0]       ctrl_q;
  logic [DIV_W-1:0] div_q, effDiv;
  logic             overrun_q, frameErr_q, txDrop_q;

  logic          txPush, txPop, txFull, txEmpty;
  logic [7:0]    txHead;
  logic [CW-1:0] txCount;
  logic          rxPush, rxPop, rxFull, rxEmpty;
  logic [7:0]    rxHead;
  logic [CW-1:0] rxCount;

  tx_state_e        txState_q, txState_d;
  logic [DIV_W-1:0] txCnt_q, txCnt_d;
  logic [2:0]       txBit_q, txBit_d;
  logic [7:0]       txShift_q, txShift_d;

  rx_state_e        rxState_q, rxState_d;
  logic [DIV_W-1:0] rxCnt_q, rxCnt_d;
  logic [2:0]       rxBit_q, rxBit_d;
  logic [7:0]       rxShift_q, rxShift_d;
  logic             rxSync1_q, rxSync2_q, rxPrev_q;
  logic             rxFall, setFrameErr;

  logic       wrAcc, rdAcc, loopback, txLine, txBusy, txIdle;
  logic [7:0] statusByte;

  assign wrAcc    = i_cyc & i_we;
  assign rdAcc    = i_cyc & ~i_we;
  assign txPush   = wrAcc & (i_addr == UART_REG_DATA);
  assign rxPop    = rdAcc & (i_addr == UART_REG_DATA);
  assign loopback = ctrl_q[CTRL_LOOPBACK];
  assign effDiv   = (div_q < DIV_W'(3)) ? DIV_W'(3) : div_q;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txFifo (
    .clk(i_clk), .rst(i_reset), .push(txPush), .pop(txPop), .wdata(i_dat),
    .rdata(txHead), .full(txFull), .empty(txEmpty), .count(txCount)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rxFifo (
    .clk(i_clk), .rst(i_reset), .push(rxPush), .pop(rxPop), .wdata(rxShift_q),
    .rdata(rxHead), .full(rxFull), .empty(rxEmpty), .count(rxCount)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_q     <= '0;
      div_q      <= DIV_RST;
      overrun_q  <= 1'b0;
      frameErr_q <= 1'b0;
      txDrop_q   <= 1'b0;
    end else begin
      if (wrAcc) begin
        case (i_addr)
          UART_REG_STATUS: begin
            if (i_dat[ST_OVERRUN])   overrun_q  <= 1'b0;
            if (i_dat[ST_FRAME_ERR]) frameErr_q <= 1'b0;
            if (i_dat[ST_TX_DROP])   txDrop_q   <= 1'b0;
          end
          UART_REG_CTRL:  ctrl_q           <= i_dat[2:0];
          UART_REG_DIVLO: div_q[7:0]       <= i_dat;
          UART_REG_DIVHI: div_q[DIV_W-1:8] <= i_dat[DIV_W-9:0];
          default: ;
        endcase
      end
      // A new error event in the same cycle as a clear keeps the flag set.
      if (rxPush && rxFull && !rxPop)   overrun_q  <= 1'b1;
      if (setFrameErr)                  frameErr_q <= 1'b1;
      if (txPush && txFull && !txPop)   txDrop_q   <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      txState_q <= TX_IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
    end else begin
      txState_q <= txState_d;
      txCnt_q   <= txCnt_d;
      txBit_q   <= txBit_d;
      txShift_q <= txShift_d;
    end
  end

  // The stop bit chains straight into the next start when a byte is waiting.
  always_comb begin
    txState_d = txState_q;
    txCnt_d   = txCnt_q;
    txBit_d   = txBit_q;
    txShift_d = txShift_q;
    txPop     = 1'b0;
    unique case (txState_q)
      TX_IDLE: if (!txEmpty) begin
        txState_d = TX_START; txPop = 1'b1; txShift_d = txHead; txCnt_d = effDiv;
      end
      TX_START: if (txCnt_q == '0) begin
        txState_d = TX_DATA; txBit_d = '0; txCnt_d = effDiv;
      end else txCnt_d = txCnt_q - 1'b1;
      TX_DATA: if (txCnt_q == '0) begin
        txCnt_d   = effDiv;
        txShift_d = txShift_q >> 1;
        if (txBit_q == 3'd7) txState_d = TX_STOP;
        else                 txBit_d   = txBit_q + 3'd1;
      end else txCnt_d = txCnt_q - 1'b1;
      TX_STOP: if (txCnt_q == '0) begin
        if (!txEmpty) begin
          txState_d = TX_START; txPop = 1'b1; txShift_d = txHead; txCnt_d = effDiv;
        end else txState_d = TX_IDLE;
      end else txCnt_d = txCnt_q - 1'b1;
    endcase
  end

  assign txLine = (txState_q == TX_START) ? 1'b0 :
                  (txState_q == TX_DATA)  ? txShift_q[0] : 1'b1;
  assign tx     = loopback ? 1'b1 : txLine;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rxSync1_q <= 1'b1;
      rxSync2_q <= 1'b1;
      rxPrev_q  <= 1'b1;
      rxState_q <= RX_IDLE;
      rxCnt_q   <= '0;
      rxBit_q   <= '0;
      rxShift_q <= '0;
    end else begin
      rxSync1_q <= loopback ? txLine : rx;
      rxSync2_q <= rxSync1_q;
      rxPrev_q  <= rxSync2_q;
      rxState_q <= rxState_d;
      rxCnt_q   <= rxCnt_d;
      rxBit_q   <= rxBit_d;
      rxShift_q <= rxShift_d;
    end
  end

  assign rxFall = rxPrev_q & ~rxSync2_q;

  // Half-period wait in START lands every later sample mid-bit.
  always_comb begin
    rxState_d   = rxState_q;
    rxCnt_d     = rxCnt_q;
    rxBit_d     = rxBit_q;
    rxShift_d   = rxShift_q;
    rxPush      = 1'b0;
    setFrameErr = 1'b0;
    unique case (rxState_q)
      RX_IDLE: if (rxFall) begin
        rxState_d = RX_START; rxCnt_d = effDiv >> 1;
      end
      RX_START: if (rxCnt_q == '0) begin
        if (rxSync2_q) rxState_d = RX_IDLE;
        else begin
          rxState_d = RX_DATA; rxBit_d = '0; rxCnt_d = effDiv;
        end
      end else rxCnt_d = rxCnt_q - 1'b1;
      RX_DATA: if (rxCnt_q == '0) begin
        rxShift_d = {rxSync2_q, rxShift_q[7:1]};
        rxCnt_d   = effDiv;
        if (rxBit_q == 3'd7) rxState_d = RX_STOP;
        else                 rxBit_d   = rxBit_q + 3'd1;
      end else rxCnt_d = rxCnt_q - 1'b1;
      RX_STOP: if (rxCnt_q == '0) begin
        rxPush      = 1'b1;
        setFrameErr = ~rxSync2_q;
        rxState_d   = RX_IDLE;
      end else rxCnt_d = rxCnt_q - 1'b1;
    endcase
  end

  assign txBusy = (txCount != '0) | (txState_q != TX_IDLE);
  assign txIdle = ~txBusy;

  always_comb begin
    statusByte               = '0;
    statusByte[ST_RX_AVAIL]  = ~rxEmpty;
    statusByte[ST_OVERRUN]   = overrun_q;
    statusByte[ST_TX_BUSY]   = txBusy;
    statusByte[ST_TX_FULL]   = txFull;
    statusByte[ST_FRAME_ERR] = frameErr_q;
    statusByte[ST_TX_IDLE]   = txIdle;
    statusByte[ST_TX_DROP]   = txDrop_q;
  end

  always_comb begin
    o_dat = 8'h00;
    case (i_addr)
      UART_REG_DATA:   o_dat = rxEmpty ? 8'h00 : rxHead;
      UART_REG_STATUS: o_dat = statusByte;
      UART_REG_CTRL:   o_dat = {5'b0, ctrl_q};
      UART_REG_DIVLO:  o_dat = div_q[7:0];
      UART_REG_DIVHI:  o_dat = 8'(div_q[DIV_W-1:8]);
      default: ;
    endcase
  end

  assign o_int[0] = ctrl_q[CTRL_RX_INT_EN] &
                    ((rxCount >= CW'(RX_THRESH)) | overrun_q | frameErr_q);
  assign o_int[1] = ctrl_q[CTRL_TX_INT_EN] & txIdle;

endmodule

// File: tb/tb_uart_buffered.sv
// Randomized self-checking bench for uart_buffered, checked against a
// queue-based model of the register-visible behaviour.
module tb_uart_buffered;
  import uart_pkg::*;

  localparam int DEPTH  = 4;
  localparam int THRESH = 1;

  logic       i_clk, i_reset, i_we, i_cyc, rx, tx;
  logic [7:0] i_dat, o_dat;
  logic [2:0] i_addr;
  logic [1:0] o_int;

  uart_buffered #(
    .SYS_CLK(1_000_000), .BAUDRATE(100_000), .FIFO_DEPTH(DEPTH),
    .RX_THRESH(THRESH), .DIV_W(16)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_dat(i_dat), .o_dat(o_dat),
    .i_addr(i_addr), .i_we(i_we), .i_cyc(i_cyc), .rx(rx), .tx(tx), .o_int(o_int)
  );

  // Free-running clock, period 10.
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Hard time limit so a stuck run still terminates.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "[TB] time limit");
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: expected RX FIFO contents and sticky flags.
  logic [7:0] rxQ [$];
  logic       mOverrun, mFrameErr, mTxDrop;
  logic [2:0] mCtrl;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Bus tasks start and end on a falling clock edge with the strobe low.
  task automatic busWrite(input logic [2:0] a, input logic [7:0] d);
    i_addr = a; i_dat = d; i_we = 1'b1; i_cyc = 1'b1;
    @(negedge i_clk);
    i_cyc = 1'b0; i_we = 1'b0;
  endtask

  task automatic busRead(input logic [2:0] a, output logic [7:0] d);
    i_addr = a; i_we = 1'b0; i_cyc = 1'b1;
    #1 d = o_dat;
    @(negedge i_clk);
    i_cyc = 1'b0;
  endtask

  function automatic logic [7:0] quietStatus();
    return {1'b0, mTxDrop, 1'b1, mFrameErr, 1'b0, 1'b0, mOverrun, rxQ.size() != 0};
  endfunction

  function automatic logic expRxInt();
    return mCtrl[0] & ((rxQ.size() >= THRESH) | mOverrun | mFrameErr);
  endfunction

  task automatic applyStimulusCtrl(input logic [7:0] c);
    busWrite(UART_REG_CTRL, c);
    mCtrl = c[2:0];
  endtask

  // Sends one byte on the tx pin and checks every clock of every bit.
  task automatic checkTxFrame(input logic [7:0] b, input int period);
    logic [9:0]  frame;
    logic [15:0] seen, want;
    logic [7:0]  st;
    frame = {1'b1, b, 1'b0};
    busWrite(UART_REG_DATA, b);
    checkOutput("tx_high_before_start", tx, 1'b1);
    for (int bitIdx = 0; bitIdx < 10; bitIdx++) begin
      seen = '0; want = '0;
      for (int k = 0; k < period; k++) begin
        @(negedge i_clk);
        seen[k] = tx;
        want[k] = frame[bitIdx];
      end
      checkOutput($sformatf("tx_b%0d_byte%02h_p%0d", bitIdx, b, period), seen, want);
    end
    busRead(UART_REG_STATUS, st);
    checkOutput("tx_idle_during_stop", st[ST_TX_IDLE], 1'b0);
    busRead(UART_REG_STATUS, st);
    checkOutput("tx_idle_after_stop", st[ST_TX_IDLE], 1'b1);
  endtask

  task automatic driveFrame(input logic [7:0] b, input logic stopBit, input int period);
    logic [9:0] f;
    f = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (period) @(negedge i_clk);
    end
    rx = 1'b1;
    repeat (20) @(negedge i_clk);
  endtask

  task automatic modelRxByte(input logic [7:0] b, input logic stopBit);
    if (rxQ.size() < DEPTH) rxQ.push_back(b);
    else                    mOverrun = 1'b1;
    if (!stopBit) mFrameErr = 1'b1;
  endtask

  task automatic checkRxDrain(input string tag);
    logic [7:0] d, want;
    int n;
    n = rxQ.size();
    for (int i = 0; i <= n; i++) begin
      want = (rxQ.size() != 0) ? rxQ.pop_front() : 8'h00;
      busRead(UART_REG_DATA, d);
      checkOutput($sformatf("%s_read%0d", tag, i), d, want);
    end
  endtask

  task automatic modelReset();
    rxQ.delete();
    mOverrun = 1'b0; mFrameErr = 1'b0; mTxDrop = 1'b0; mCtrl = '0;
  endtask

  initial begin
    logic [7:0] d, b;
    logic [7:0] lb [2];
    logic       sawLow;
    int         dv;

    i_reset = 1'b1; i_dat = '0; i_addr = '0; i_we = 1'b0; i_cyc = 1'b0; rx = 1'b1;
    modelReset();
    #1;
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_int", o_int, 2'b00);
    repeat (3) @(negedge i_clk);
    busRead(UART_REG_STATUS, d);
    checkOutput("reset_status_in_reset", d, 8'h20);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Register map after reset.
    busRead(UART_REG_STATUS, d); checkOutput("status_after_reset", d, 8'h20);
    busRead(UART_REG_DIVLO, d);  checkOutput("div_lo_reset", d, 8'h09);
    busRead(UART_REG_DIVHI, d);  checkOutput("div_hi_reset", d, 8'h00);
    busRead(UART_REG_CTRL, d);   checkOutput("ctrl_reset", d, 8'h00);
    for (int a = 5; a < 8; a++) begin
      busWrite(3'(a), 8'($urandom));
      busRead(3'(a), d);
      checkOutput($sformatf("unmapped_%0d", a), d, 8'h00);
    end
    busRead(UART_REG_CTRL, d); checkOutput("ctrl_untouched", d, 8'h00);
    b = 8'($urandom);
    busWrite(UART_REG_DIVHI, b);
    busRead(UART_REG_DIVHI, d); checkOutput("div_hi_rw", d, b);
    busWrite(UART_REG_DIVHI, 8'h00);

    // TX framing at the reset divisor, then at random divisors including the clamp region.
    checkTxFrame(8'h55, 10);
    for (int i = 0; i < 4; i++) begin
      dv = (i == 0) ? 0 : $urandom_range(1, 12);
      busWrite(UART_REG_DIVLO, 8'(dv));
      busRead(UART_REG_DIVLO, d);
      checkOutput("div_lo_rw", d, 8'(dv));
      checkTxFrame(8'($urandom), ((dv < 3) ? 3 : dv) + 1);
    end
    busWrite(UART_REG_DIVLO, 8'h09);

    // TX FIFO overflow: the engine holds one byte and the FIFO holds DEPTH more.
    applyStimulusCtrl(8'h02);
    #1 checkOutput("tx_int_idle", o_int, 2'b10);
    @(negedge i_clk);
    for (int i = 0; i < DEPTH + 2; i++) busWrite(UART_REG_DATA, 8'($urandom));
    mTxDrop = 1'b1;
    busRead(UART_REG_STATUS, d); checkOutput("tx_overflow_status", d, 8'h4C);
    checkOutput("tx_int_busy", o_int, 2'b00);
    busWrite(UART_REG_STATUS, 8'h40);
    mTxDrop = 1'b0;
    busRead(UART_REG_STATUS, d); checkOutput("tx_drop_cleared", d, 8'h0C);
    repeat (600) @(negedge i_clk);
    busRead(UART_REG_STATUS, d); checkOutput("tx_drained_status", d, quietStatus());
    checkOutput("tx_int_drained", o_int, 2'b10);

    // Loopback: bytes return through RX while the pin stays high.
    for (int r = 0; r < 2; r++) begin
      lb[0] = (r == 0) ? 8'hA5 : 8'($urandom);
      lb[1] = (r == 0) ? 8'h3C : 8'($urandom);
      applyStimulusCtrl(8'h04);
      busWrite(UART_REG_DATA, lb[0]);
      busWrite(UART_REG_DATA, lb[1]);
      sawLow = 1'b0;
      for (int k = 0; k < 230; k++) begin
        @(negedge i_clk);
        if (tx == 1'b0) sawLow = 1'b1;
      end
      checkOutput("loopback_pin_low_seen", sawLow, 1'b0);
      rxQ.push_back(lb[0]);
      rxQ.push_back(lb[1]);
      busRead(UART_REG_STATUS, d); checkOutput("loopback_status", d, quietStatus());
      checkRxDrain("loopback");
      busRead(UART_REG_STATUS, d); checkOutput("loopback_empty_status", d, quietStatus());
    end

    // External frames into a full RX FIFO.
    applyStimulusCtrl(8'h01);
    for (int i = 0; i < DEPTH + 2; i++) begin
      b = 8'($urandom);
      driveFrame(b, 1'b1, 10);
      modelRxByte(b, 1'b1);
    end
    busRead(UART_REG_STATUS, d); checkOutput("overrun_status", d, quietStatus());
    checkOutput("rx_int_overrun", o_int[0], expRxInt());
    checkRxDrain("overrun");
    checkOutput("rx_int_sticky_overrun", o_int[0], expRxInt());
    busWrite(UART_REG_STATUS, 8'h02);
    mOverrun = 1'b0;
    busRead(UART_REG_STATUS, d); checkOutput("overrun_cleared", d, quietStatus());
    checkOutput("rx_int_cleared", o_int[0], expRxInt());

    // Bad stop bit still delivers the byte and flags a framing error.
    driveFrame(8'h81, 1'b0, 10);
    modelRxByte(8'h81, 1'b0);
    b = 8'($urandom);
    driveFrame(b, 1'b1, 10);
    modelRxByte(b, 1'b1);
    busRead(UART_REG_STATUS, d); checkOutput("frame_err_status", d, quietStatus());
    checkRxDrain("frame_err");
    checkOutput("rx_int_frame_err", o_int[0], expRxInt());
    busWrite(UART_REG_STATUS, 8'h10);
    mFrameErr = 1'b0;
    busRead(UART_REG_STATUS, d); checkOutput("frame_err_cleared", d, quietStatus());

    // A two-clock low pulse is rejected at the half-bit recheck.
    rx = 1'b0;
    repeat (2) @(negedge i_clk);
    rx = 1'b1;
    repeat (40) @(negedge i_clk);
    busRead(UART_REG_STATUS, d); checkOutput("glitch_ignored", d, quietStatus());

    // Reset in the middle of a frame with another byte queued.
    applyStimulusCtrl(8'h00);
    busWrite(UART_REG_DATA, 8'h00);
    busWrite(UART_REG_DATA, 8'($urandom));
    repeat (15) @(negedge i_clk);
    checkOutput("tx_low_midframe", tx, 1'b0);
    #2 i_reset = 1'b1;
    #1 checkOutput("tx_high_on_reset", tx, 1'b1);
    modelReset();
    @(negedge i_clk);
    busRead(UART_REG_STATUS, d); checkOutput("status_in_midframe_reset", d, 8'h20);
    i_reset = 1'b0;
    @(negedge i_clk);
    busRead(UART_REG_STATUS, d); checkOutput("status_after_midframe_reset", d, quietStatus());
    checkTxFrame(8'($urandom), 10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
